// File: rtl/game_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | game_pkg: shared game types, UART command constants and decoder    |
// | state encoding.                                           rev 1.1  |
// +--------------------------------------------------------------------+
package game_pkg;

    typedef enum logic [2:0] {
        DIR_UP    = 3'd0,
        DIR_DOWN  = 3'd1,
        DIR_LEFT  = 3'd2,
        DIR_RIGHT = 3'd3,
        DIR_WAIT  = 3'd4
    } direction_t;

    localparam logic [7:0] UART_HEADER   = 8'hA5;
    localparam logic [7:0] CMD_START     = 8'h01;
    localparam logic [7:0] CMD_DIR       = 8'h02;
    localparam logic [7:0] CMD_COLLISION = 8'h03;
    localparam logic [7:0] CMD_RESTART   = 8'h04;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GET_CMD = 2'd1,
        ST_GET_ARG = 2'd2,
        ST_GET_CHK = 2'd3
    } dec_state_t;

    // Callers must range-check the argument (<= 4) before using the result.
    function automatic direction_t arg_to_dir(input logic [2:0] arg);
        case (arg)
            3'd0:    return DIR_UP;
            3'd1:    return DIR_DOWN;
            3'd2:    return DIR_LEFT;
            3'd3:    return DIR_RIGHT;
            default: return DIR_WAIT;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_frame_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_frame_decoder: parses HEADER/CMD/ARG/CHK frames into remote   |
// | game controls, with checksum and inter-byte timeout.      rev 1.1  |
// +--------------------------------------------------------------------+
module uart_frame_decoder
    import game_pkg::*;
#(
    parameter logic [7:0]  HEADER         = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 650_000,
    parameter int unsigned CNT_W          = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic [1:0]       uart_state_selector,
    output logic             remote_collision,
    output direction_t       remote_dir,
    output logic             frame_err,
    output logic [7:0]       frames_ok
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    dec_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       cmd_q, cmd_d;
    logic [7:0]       arg_q, arg_d;
    logic [1:0]       sel_q, sel_d;
    logic             col_q, col_d;
    direction_t       dir_q, dir_d;
    logic             err_q, err_d;
    logic [7:0]       fok_q, fok_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            cmd_q   <= '0;
            arg_q   <= '0;
            sel_q   <= 2'b00;
            col_q   <= 1'b0;
            dir_q   <= DIR_WAIT;
            err_q   <= 1'b0;
            fok_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            arg_q   <= arg_d;
            sel_q   <= sel_d;
            col_q   <= col_d;
            dir_q   <= dir_d;
            err_q   <= err_d;
            fok_q   <= fok_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        arg_d   = arg_q;
        sel_d   = 2'b00;
        col_d   = 1'b0;
        dir_d   = dir_q;
        err_d   = 1'b0;
        fok_d   = fok_q;

        // A byte arriving in the expiry cycle wins over the timeout.
        if (state_q == ST_IDLE || rx_valid) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
            err_d   = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (rx_valid && rx_data == HEADER) begin
                    state_d = ST_GET_CMD;
                end
            end
            ST_GET_CMD: begin
                if (rx_valid) begin
                    cmd_d   = rx_data;
                    state_d = ST_GET_ARG;
                end
            end
            ST_GET_ARG: begin
                if (rx_valid) begin
                    arg_d   = rx_data;
                    state_d = ST_GET_CHK;
                end
            end
            ST_GET_CHK: begin
                if (rx_valid) begin
                    state_d = ST_IDLE;
                    if (rx_data != (HEADER ^ cmd_q ^ arg_q)) begin
                        err_d = 1'b1;
                    end else begin
                        case (cmd_q)
                            CMD_START: begin
                                sel_d = 2'b01;
                                fok_d = fok_q + 8'd1;
                            end
                            CMD_RESTART: begin
                                sel_d = 2'b10;
                                fok_d = fok_q + 8'd1;
                            end
                            CMD_COLLISION: begin
                                col_d = 1'b1;
                                fok_d = fok_q + 8'd1;
                            end
                            CMD_DIR: begin
                                if (arg_q <= 8'd4) begin
                                    dir_d = arg_to_dir(arg_q[2:0]);
                                    fok_d = fok_q + 8'd1;
                                end else begin
                                    err_d = 1'b1;
                                end
                            end
                            default: err_d = 1'b1;
                        endcase
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign uart_state_selector = sel_q;
    assign remote_collision    = col_q;
    assign remote_dir          = dir_q;
    assign frame_err           = err_q;
    assign frames_ok           = fok_q;

endmodule
`default_nettype wire

// File: doc/uart_frame_decoder.md
Name: uart_frame_decoder

Overview:
- Sits directly upstream of the game-mode FSM, between the uart_rx byte receiver and gamemode_control.
- Parses 4-byte command frames sent by the remote board and produces the control inputs gamemode_control consumes:
  - uart_state_selector: remote start or restart request.
  - remote_collision: remote player crashed.
  - remote_dir: the remote player's steering direction.
- Rejects malformed, corrupted or stalled frames and flags them on frame_err.

Parameters:
- HEADER, 8'hA5, frame start byte.
- TIMEOUT_CYCLES, 650_000, maximum idle cycles between bytes inside one frame (10 ms at 65 MHz).
- CNT_W, 20, width of the timeout counter; must satisfy 2**CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock (65 MHz pixel domain).
- rst_n  input  1  reset, synchronous, active-low.
- rx_data  input  8  byte from uart_rx.
- rx_valid  input  1  one-cycle strobe; rx_data is valid only while this is high.
- uart_state_selector  output  2  one-cycle pulse: 2'b01 = remote START, 2'b10 = remote RESTART, else 2'b00.
- remote_collision  output  1  one-cycle pulse on a valid COLLISION frame.
- remote_dir  output  3  last valid direction (direction_t from game_pkg), held until the next DIR frame.
- frame_err  output  1  one-cycle pulse on bad checksum, unknown command, bad DIR argument or timeout.
- frames_ok  output  8  count of accepted frames, wraps at 255 -> 0.

Behaviour:
- Frame format: HEADER, CMD, ARG, CHK, where CHK = HEADER ^ CMD ^ ARG.
- Commands:
  - 8'h01 START.
  - 8'h02 DIR; ARG 0..4 maps to UP, DOWN, LEFT, RIGHT, WAIT; ARG > 4 is invalid.
  - 8'h03 COLLISION.
  - 8'h04 RESTART.
- FSM states: IDLE -> GET_CMD -> GET_ARG -> GET_CHK -> IDLE.
  - IDLE: on rx_valid with rx_data == HEADER, go to GET_CMD. Any other byte is dropped silently (no frame_err).
  - GET_CMD and GET_ARG: on rx_valid, latch the byte and advance.
  - GET_CHK: on rx_valid, evaluate the frame and return to IDLE.
- A HEADER value arriving mid-frame is treated as data. There is no resync; the checksum catches misalignment.
- Commit: outputs are registered and appear on the cycle after the rx_valid carrying CHK (latency 1).
- Valid frame effects:
  - START: uart_state_selector = 01 for one cycle.
  - RESTART: uart_state_selector = 10 for one cycle.
  - COLLISION: remote_collision = 1 for one cycle.
  - DIR: remote_dir updated.
  - frames_ok increments.
- Invalid frame (checksum mismatch, unknown CMD, DIR with ARG > 4): frame_err pulses for one cycle; no other output changes and frames_ok is unchanged.
- Timeout:
  - The counter clears on every accepted byte and on entry to IDLE, and counts only while the state is not IDLE.
  - When it reaches TIMEOUT_CYCLES-1 with no rx_valid, the FSM returns to IDLE and frame_err pulses.
  - rx_valid in the same cycle as expiry: the byte is accepted, no timeout.
- All pulse outputs default to 0 every cycle; pulses never stretch.
- Back-to-back frames (a new HEADER in the cycle right after CHK) must be accepted with no dead cycle.
- Reset values: FSM = IDLE, counter = 0, uart_state_selector = 2'b00, remote_collision = 0, remote_dir = WAIT, frame_err = 0, frames_ok = 0.
- Reset asserted mid-frame discards the partial frame; there is no error pulse.

Decomposition:
- game_pkg gains:
  - The command constants CMD_START, CMD_DIR, CMD_COLLISION, CMD_RESTART, plus UART_HEADER.
  - The decoder state typedef.
  - The reuse of the existing direction typedef and the ARG-to-direction mapping function.
- No sub-module. The timeout counter stays inline; the FSM plus datapath is about 150-200 lines.

Test Plan:
- Reset, then bytes A5 01 00 A4 -> uart_state_selector = 01 for exactly one cycle, one cycle after the CHK byte; frames_ok = 1.
- A5 02 03 A4 -> remote_dir = RIGHT and held; then A5 02 07 A0 -> frame_err pulse, remote_dir stays RIGHT.
- A5 03 00 A6 immediately followed by A5 04 00 A1 with no gap -> remote_collision pulse, then uart_state_selector = 10 pulse; frames_ok = 2.
- A5 01 00 00 (bad CHK) -> frame_err pulse only. Then 3C 11 (non-header bytes in IDLE) -> no frame_err, no output change.
- A5 01, then TIMEOUT_CYCLES idle cycles -> frame_err pulse, FSM in IDLE. A following full START frame decodes correctly.
- A5 01 then rst_n low for 1 cycle, then 00 A4 -> nothing decoded (bytes dropped in IDLE), remote_dir = WAIT, frames_ok = 0, no frame_err.
